idex_hazard_stage: RTL and testbench

- ID/EX pipeline register combined with a load-use interlock for the LC3 5-stage pipeline.
- Sits between decode and the forwarding/EX stage, and produces the idexIR, _idexA and _idexB values that forwarding consumes.
- Forwarding cannot cover a load followed immediately by a dependent instruction, so this block inserts bubbles and holds IF/ID:
  - 1 bubble for LD/LDR.
  - 2 bubbles for LDI, whose MEM access is two cycles.
- Also squashes the ID/EX slot on a taken control transfer.

---
 rtl/lc3_pkg.sv | 29 ++
 rtl/idex_hazard_stage_if.sv | 26 ++
 rtl/lc3_src_decode.sv | 44 ++++
 rtl/idex_hazard_stage.sv | 79 +++++++
 tb/tb_idex_hazard_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline definitions: opcodes, bubble encoding and hazard FSM states.
// Used by the decode, interlock and later the forwarding rewrite.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    // BR with nzp=000: never taken, writes no register.
    localparam logic [15:0] NOP_IR = 16'h0000;

    typedef logic [0:0] hz_state_t;
    localparam hz_state_t ST_RUN      = 1'b0;
    localparam hz_state_t ST_LDI_HOLD = 1'b1;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/idex_hazard_stage_if.sv
// IF/ID -> ID/EX bus: decode-side operands in, registered EX-side operands and stall out.
// The stage is the slave; the decode/IF side is the master.
interface idex_hazard_stage_if #(
    parameter int DW = 16
);
    logic [DW-1:0] ifid_ir;
    logic [DW-1:0] ifid_pc;
    logic [DW-1:0] ifid_a;
    logic [DW-1:0] ifid_b;
    logic          ifid_stall;
    logic [DW-1:0] idex_ir;
    logic [DW-1:0] idex_pc;
    logic [DW-1:0] idex_a;
    logic [DW-1:0] idex_b;
    logic          idex_valid;

    modport master (
        output ifid_ir, ifid_pc, ifid_a, ifid_b,
        input  ifid_stall, idex_ir, idex_pc, idex_a, idex_b, idex_valid
    );

    modport slave (
        input  ifid_ir, ifid_pc, ifid_a, ifid_b,
        output ifid_stall, idex_ir, idex_pc, idex_a, idex_b, idex_valid
    );
endinterface

// File: rtl/lc3_src_decode.sv
// Source-register decode of an LC3 IR: which register fields the instruction reads.
// Latency: combinational. Backpressure: none.
// Store data registers (ST/STI/STR [11:9]) are reported as src2.
module lc3_src_decode
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    output logic        src1_used,
    output logic [2:0]  src1,
    output logic        src2_used,
    output logic [2:0]  src2
);

    always_comb begin
        src1_used = 1'b0;
        src2_used = 1'b0;
        src1      = ir[8:6];
        src2      = ir[2:0];
        case (ir[15:12])
            OP_ADD, OP_AND: begin
                src1_used = 1'b1;
                src2_used = ~ir[5];
            end
            OP_NOT, OP_JMP, OP_LDR: begin
                src1_used = 1'b1;
            end
            OP_JSR: begin
                src1_used = ~ir[11];
            end
            OP_STR: begin
                src1_used = 1'b1;
                src2_used = 1'b1;
                src2      = ir[11:9];
            end
            OP_ST, OP_STI: begin
                src2_used = 1'b1;
                src2      = ir[11:9];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use interlock (1 bubble LD/LDR, 2 bubbles LDI) and flush squash.
// Latency: 1 cycle ifid_* -> idex_*; ifid_stall is combinational in the same cycle.
// Backpressure: ifid_stall holds PC and IF/ID while bubbles are inserted; flush overrides the stall.
module idex_hazard_stage
    import lc3_pkg::*;
#(
    parameter int            DW     = 16,
    parameter int            CNT_W  = 16,
    parameter logic [DW-1:0] NOP_IR = lc3_pkg::NOP_IR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    idex_hazard_stage_if.slave   bus,
    output logic [CNT_W-1:0]     stall_cnt
);

    hz_state_t  state;
    logic       src1_used;
    logic       src2_used;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [2:0] load_dest;
    logic       idex_is_load;
    logic       hazard;
    logic       interlock;

    lc3_src_decode u_src_decode (
        .ir        (bus.ifid_ir[15:0]),
        .src1_used (src1_used),
        .src1      (src1),
        .src2_used (src2_used),
        .src2      (src2)
    );

    assign load_dest    = bus.idex_ir[11:9];
    assign idex_is_load = bus.idex_valid && is_load(bus.idex_ir[15:12]);
    assign hazard       = idex_is_load &&
                          ((src1_used && (src1 == load_dest)) ||
                           (src2_used && (src2 == load_dest)));

    // The second LDI bubble is unconditional: the load result is still one cycle short.
    assign interlock      = ((state == ST_RUN) && hazard) || (state == ST_LDI_HOLD);
    assign bus.ifid_stall = interlock && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.idex_ir    <= NOP_IR;
            bus.idex_pc    <= '0;
            bus.idex_a     <= '0;
            bus.idex_b     <= '0;
            bus.idex_valid <= 1'b0;
            stall_cnt      <= '0;
            state          <= ST_RUN;
        end else if (flush) begin
            bus.idex_ir    <= NOP_IR;
            bus.idex_valid <= 1'b0;
            state          <= ST_RUN;
        end else if (interlock) begin
            bus.idex_ir    <= NOP_IR;
            bus.idex_valid <= 1'b0;
            if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((state == ST_RUN) && (bus.idex_ir[15:12] == OP_LDI)) begin
                state <= ST_LDI_HOLD;
            end else begin
                state <= ST_RUN;
            end
        end else begin
            bus.idex_ir    <= bus.ifid_ir;
            bus.idex_pc    <= bus.ifid_pc;
            bus.idex_a     <= bus.ifid_a;
            bus.idex_b     <= bus.ifid_b;
            bus.idex_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Scoreboard bench for idex_hazard_stage: directed IR vectors with hand-computed stall/bubble/count.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_idex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt_s;

    idex_hazard_stage_if #(.DW(16)) bus ();
    idex_hazard_stage_if #(.DW(16)) bus_s ();

    assign bus_s.ifid_ir = bus.ifid_ir;
    assign bus_s.ifid_pc = bus.ifid_pc;
    assign bus_s.ifid_a  = bus.ifid_a;
    assign bus_s.ifid_b  = bus.ifid_b;

    idex_hazard_stage #(.DW(16), .CNT_W(16), .NOP_IR(16'h0000)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    idex_hazard_stage #(.DW(16), .CNT_W(4), .NOP_IR(16'h0000)) u_dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus_s),
        .stall_cnt (stall_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic        stall;
        logic [15:0] oir;
        logic        ov;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pc_of(input logic [15:0] ir);
        return ir ^ 16'h1111;
    endfunction

    // Inputs change just after the falling edge; one expectation per cycle.
    task automatic step(input logic [15:0] ir, input logic fl, input logic rn,
                        input logic es, input logic [15:0] eir, input logic ev,
                        input logic [15:0] ec);
        exp_t e;
        @(negedge clk);
        #1;
        bus.ifid_ir = ir;
        bus.ifid_pc = pc_of(ir);
        bus.ifid_a  = ir + 16'd1;
        bus.ifid_b  = ~ir;
        flush       = fl;
        rst_n       = rn;
        e.ir = ir; e.stall = es; e.oir = eir; e.ov = ev; e.cnt = ec;
        sb.push_back(e);
    endtask

    // Monitor: stall and pre-edge hold before the rising edge, registered outputs after it.
    initial begin
        exp_t e;
        exp_t prev;
        logic have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ifid_stall", {31'd0, bus.ifid_stall}, {31'd0, e.stall});
                if (have_prev) begin
                    chk("idex_ir_hold", {16'd0, bus.idex_ir}, {16'd0, prev.oir});
                    chk("stall_cnt_hold", {16'd0, stall_cnt}, {16'd0, prev.cnt});
                end
                @(posedge clk);
                #1;
                chk("idex_ir", {16'd0, bus.idex_ir}, {16'd0, e.oir});
                chk("idex_valid", {31'd0, bus.idex_valid}, {31'd0, e.ov});
                chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
                chk("stall_cnt_sat4", {28'd0, stall_cnt_s},
                    (e.cnt > 16'd15) ? 32'd15 : {16'd0, e.cnt});
                if (e.ov) begin
                    chk("idex_pc", {16'd0, bus.idex_pc}, {16'd0, pc_of(e.oir)});
                    chk("idex_a", {16'd0, bus.idex_a}, {16'd0, e.oir + 16'd1});
                    chk("idex_b", {16'd0, bus.idex_b}, {16'd0, ~e.oir});
                end
                prev      = e;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        int c;
        int wait_cyc;
        rst_n       = 1'b0;
        flush       = 1'b1;
        bus.ifid_ir = 16'h0000;
        bus.ifid_pc = 16'h0000;
        bus.ifid_a  = 16'h0000;
        bus.ifid_b  = 16'h0000;

        // ir     flush rst  stall  idex_ir  valid  cnt
        step(16'h0000, 1, 0, 0, 16'h0000, 0, 0);
        step(16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        // LDR R1 then dependent ADD R3,R1,R4: one bubble
        step(16'h6280, 0, 1, 0, 16'h6280, 1, 0);
        step(16'h1644, 0, 1, 1, 16'h0000, 0, 1);
        step(16'h1644, 0, 1, 0, 16'h1644, 1, 1);
        // LDR R1 then independent ADD R3,R5,R6: no stall
        step(16'h6280, 0, 1, 0, 16'h6280, 1, 1);
        step(16'h1746, 0, 1, 0, 16'h1746, 1, 1);
        // LDI R1 then STR R1,R5: two bubbles
        step(16'hA201, 0, 1, 0, 16'hA201, 1, 1);
        step(16'h7340, 0, 1, 1, 16'h0000, 0, 2);
        step(16'h7340, 0, 1, 1, 16'h0000, 0, 3);
        step(16'h7340, 0, 1, 0, 16'h7340, 1, 3);
        // LDI hazard with flush in the hold cycle cancels the second bubble
        step(16'hA201, 0, 1, 0, 16'hA201, 1, 3);
        step(16'h7340, 0, 1, 1, 16'h0000, 0, 4);
        step(16'h7340, 1, 1, 0, 16'h0000, 0, 4);
        step(16'h1746, 0, 1, 0, 16'h1746, 1, 4);
        // flush on a hazard cycle: no stall, no count
        step(16'h6280, 0, 1, 0, 16'h6280, 1, 4);
        step(16'h1644, 1, 1, 0, 16'h0000, 0, 4);
        // reset mid-LDI_HOLD
        step(16'hA201, 0, 1, 0, 16'hA201, 1, 4);
        step(16'h7340, 0, 1, 1, 16'h0000, 0, 5);
        step(16'h7340, 0, 0, 1, 16'h0000, 0, 0);
        step(16'h1746, 0, 1, 0, 16'h1746, 1, 0);
        step(16'h1746, 0, 0, 0, 16'h0000, 0, 0);
        // other source forms: NOT, ST, ADD imm (no hazard), JMP, JSR (none), JSRR, STI, AND reg
        step(16'h2200, 0, 1, 0, 16'h2200, 1, 0);
        step(16'h947F, 0, 1, 1, 16'h0000, 0, 1);
        step(16'h947F, 0, 1, 0, 16'h947F, 1, 1);
        step(16'h2200, 0, 1, 0, 16'h2200, 1, 1);
        step(16'h3201, 0, 1, 1, 16'h0000, 0, 2);
        step(16'h3201, 0, 1, 0, 16'h3201, 1, 2);
        step(16'h2200, 0, 1, 0, 16'h2200, 1, 2);
        step(16'h14E1, 0, 1, 0, 16'h14E1, 1, 2);
        step(16'h66C0, 0, 1, 0, 16'h66C0, 1, 2);
        step(16'hC0C0, 0, 1, 1, 16'h0000, 0, 3);
        step(16'hC0C0, 0, 1, 0, 16'hC0C0, 1, 3);
        step(16'h66C0, 0, 1, 0, 16'h66C0, 1, 3);
        step(16'h48C0, 0, 1, 0, 16'h48C0, 1, 3);
        step(16'h66C0, 0, 1, 0, 16'h66C0, 1, 3);
        step(16'h40C0, 0, 1, 1, 16'h0000, 0, 4);
        step(16'h40C0, 0, 1, 0, 16'h40C0, 1, 4);
        step(16'h2200, 0, 1, 0, 16'h2200, 1, 4);
        step(16'hB201, 0, 1, 1, 16'h0000, 0, 5);
        step(16'hB201, 0, 1, 0, 16'hB201, 1, 5);
        step(16'h2200, 0, 1, 0, 16'h2200, 1, 5);
        step(16'h54C1, 0, 1, 1, 16'h0000, 0, 6);
        step(16'h54C1, 0, 1, 0, 16'h54C1, 1, 6);
        // repeated LDR/ADD hazards drive the 4-bit counter into saturation
        c = 6;
        for (int k = 0; k < 20; k++) begin
            step(16'h6280, 0, 1, 0, 16'h6280, 1, 16'(c));
            c++;
            step(16'h1644, 0, 1, 1, 16'h0000, 0, 16'(c));
            step(16'h1644, 0, 1, 0, 16'h1644, 1, 16'(c));
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        repeat (2) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
